// File: rtl/param_fifo_v.sv
// Synchronous FIFO with registered read data and pointer-derived status flags.
// Optional sticky overflow/underflow flags are built when PARAM_FIFO_ERR_EN is defined.
module param_fifo_v #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [W-1:0]  d_in,
  output logic          full,
  input  logic          rd_en,
  output logic [W-1:0]  d_out,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         wr_acc;
  logic         rd_acc;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty  = (wp == rp);
  assign full   = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign count  = wp - rp;
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      d_out <= '0;
    end else begin
      if (wr_acc) begin
        wp <= wp + 1'b1;
      end
      if (rd_acc) begin
        rp    <= rp + 1'b1;
        d_out <= mem[rp[AW-1:0]];
      end
    end
  end

  // Storage is never cleared; writes are simply blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && resetn) begin
      mem[wp[AW-1:0]] <= d_in;
    end
  end

`ifdef PARAM_FIFO_ERR_EN
  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end else if (err_clr) begin
        udf <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo_v.sv
// Bench for param_fifo_v: directed steps plus random traffic, checked against a queue model.
module tb_param_fifo_v;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  d_in = '0;
  logic [W-1:0]  d_out;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          udf;
  logic [AW:0]   count;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus the last popped word and flags.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ovf  = 1'b0;
  logic         m_udf  = 1'b0;

  always #5 clk = ~clk;

  param_fifo_v #(.W(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .d_in    (d_in),
    .full    (full),
    .rd_en   (rd_en),
    .d_out   (d_out),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf),
    .err_clr (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".d_out"}, 32'(d_out), 32'(m_dout));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".udf"},   32'(udf),   32'(m_udf));
  endtask

  // One clock cycle of stimulus; the model advances from its pre-edge state.
  task automatic step(input string tag, input logic w, input logic [W-1:0] din,
                      input logic r, input logic clr);
    bit was_full;
    bit was_empty;
    wr_en   = w;
    d_in    = din;
    rd_en   = r;
    err_clr = clr;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    if (r && !was_empty) m_dout = q.pop_front();
    if (w && !was_full) q.push_back(din);
`ifdef PARAM_FIFO_ERR_EN
    if (w && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (r && was_empty) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;
`endif
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    $display("txn %s wr=%0b din=%02h rd=%0b clr=%0b -> d_out=%02h count=%0d full=%0b empty=%0b",
             tag, w, din, r, clr, d_out, count, full, empty);
    chk_all(tag);
  endtask

  initial begin
    // Reset state, both while held and after release.
    #12;
    chk_all("reset_held");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset_released");

    // Fill to full.
    step("fill", 1'b1, 8'h11, 1'b0, 1'b0);
    step("fill", 1'b1, 8'h22, 1'b0, 1'b0);
    step("fill", 1'b1, 8'h33, 1'b0, 1'b0);
    step("fill", 1'b1, 8'h44, 1'b0, 1'b0);

    // Full with simultaneous read/write: read accepted, write dropped.
    step("full_rw", 1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_rw.d_out_11", 32'(d_out), 32'h11);

    // Drain the rest.
    step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain.d_out_44", 32'(d_out), 32'h44);

    // Empty with simultaneous read/write: write accepted, read dropped.
    step("empty_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
    step("empty_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_rd.d_out_aa", 32'(d_out), 32'hAA);
    step("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Streaming across pointer roll-over with two words preloaded.
    step("preload", 1'b1, 8'h80, 1'b0, 1'b0);
    step("preload", 1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("stream", 1'b1, 8'(8'h82 + i), 1'b1, 1'b0);
    end
    chk("stream.count_2", 32'(count), 32'd2);

    // Random traffic: write-biased, balanced, then read-biased phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 80; i++) begin
        logic w;
        logic r;
        logic c;
        w = ($urandom_range(0, 3) < 3 - ph);
        r = ($urandom_range(0, 3) < 1 + ph);
        c = ($urandom_range(0, 7) == 0);
        step("rand", w, 8'($urandom), r, c);
      end
    end

    // Reset mid-operation with three words stored.
    for (int i = 0; i < DEPTH; i++) step("pre_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pre_rst_wr", 1'b1, 8'hC1, 1'b0, 1'b0);
    step("pre_rst_wr", 1'b1, 8'hC2, 1'b0, 1'b0);
    step("pre_rst_wr", 1'b1, 8'hC3, 1'b0, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    chk_all("async_rst");
    #2;
    resetn = 1'b1;
    step("post_rst_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst.d_out_5a", 32'(d_out), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
